// File: rtl/des_round_key_sequencer.sv
// Round-key bank for an iterative DES engine: captures all round keys at once and
// streams them forward (encrypt) or reversed (decrypt). Optional macro: WEAK_KEY_DETECT_EN.
module des_round_key_sequencer #(
   parameter  int unsigned NUM_ROUNDS = 16,
   parameter  int unsigned KEY_W      = 48,
   localparam int unsigned CNT_W      = $clog2(NUM_ROUNDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] round_keys_in [NUM_ROUNDS],
   input  logic             key_load,
   output logic             key_load_ready,
   output logic             key_loaded,
   input  logic             start,
   input  logic             decrypt,
   output logic             start_ready,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic [KEY_W-1:0] rk_out,
   output logic [CNT_W-1:0] rk_round,
   output logic             rk_last,
   input  logic             abort,
   output logic             done
`ifdef WEAK_KEY_DETECT_EN
   ,
   output logic             weak_key
`endif
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOADED, S_STREAM} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             load_en;
   logic             done_d;
   logic             valid_d;
   logic             last_d;
   logic [CNT_W-1:0] idx_d;
   logic [KEY_W-1:0] bank_q [NUM_ROUNDS];

   assign key_load_ready = (state_q != S_STREAM);
   assign start_ready    = (state_q == S_LOADED) && !key_load;

   // Next-state logic; load always beats start, abort always beats a handshake
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      load_en = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (key_load) begin
               load_en = 1'b1;
               state_d = S_LOADED;
            end
         end
         S_LOADED: begin
            if (key_load) begin
               load_en = 1'b1;
            end else if (start) begin
               dir_d   = decrypt;
               cnt_d   = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (abort) begin
               cnt_d   = '0;
               state_d = S_LOADED;
            end else if (rk_ready) begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_LOADED;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      valid_d = (state_d == S_STREAM);
      last_d  = valid_d && (cnt_d == LAST_CNT);
      idx_d   = dir_d ? (LAST_CNT - cnt_d) : cnt_d;
   end

   // State, bank and registered stream outputs (computed from next-state values)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         key_loaded <= 1'b0;
         rk_valid   <= 1'b0;
         rk_out     <= '0;
         rk_round   <= '0;
         rk_last    <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i < int'(NUM_ROUNDS); i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         key_loaded <= key_loaded | load_en;
         rk_valid   <= valid_d;
         rk_out     <= valid_d ? bank_q[idx_d] : '0;
         rk_round   <= valid_d ? cnt_d : '0;
         rk_last    <= last_d;
         done       <= done_d;
         if (load_en) begin
            for (int i = 0; i < int'(NUM_ROUNDS); i++) begin
               bank_q[i] <= round_keys_in[i];
            end
         end
      end
   end

`ifdef WEAK_KEY_DETECT_EN
   logic weak_c;

   // A DES weak key yields identical round keys in every round
   always_comb begin
      weak_c = 1'b1;
      for (int i = 1; i < int'(NUM_ROUNDS); i++) begin
         if (round_keys_in[i] != round_keys_in[0]) begin
            weak_c = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         weak_key <= 1'b0;
      end else if (load_en) begin
         weak_key <= weak_c;
      end
   end
`endif

endmodule

// File: tb/tb_des_round_key_sequencer.sv
// Self-checking bench for des_round_key_sequencer: vector table, hand-written corner
// sequences and randomized streams checked against a queue-based key-order model.
module tb_des_round_key_sequencer;

   localparam int unsigned NR = 16;
   localparam int unsigned KW = 48;
   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst;
   logic [KW-1:0] round_keys_in [NR];
   logic          key_load;
   logic          key_load_ready;
   logic          key_loaded;
   logic          start;
   logic          decrypt;
   logic          start_ready;
   logic          rk_valid;
   logic          rk_ready;
   logic [KW-1:0] rk_out;
   logic [CW-1:0] rk_round;
   logic          rk_last;
   logic          abort;
   logic          done;
`ifdef WEAK_KEY_DETECT_EN
   logic          weak_key;
`endif

   logic [KW-1:0] bank_m [NR];
   int            n_cmp;
   int            n_bad;

   des_round_key_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .round_keys_in (round_keys_in),
      .key_load      (key_load),
      .key_load_ready(key_load_ready),
      .key_loaded    (key_loaded),
      .start         (start),
      .decrypt       (decrypt),
      .start_ready   (start_ready),
      .rk_valid      (rk_valid),
      .rk_ready      (rk_ready),
      .rk_out        (rk_out),
      .rk_round      (rk_round),
      .rk_last       (rk_last),
      .abort         (abort),
      .done          (done)
`ifdef WEAK_KEY_DETECT_EN
      ,
      .weak_key      (weak_key)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit model_all_equal();
      for (int i = 1; i < int'(NR); i++) begin
         if (bank_m[i] != bank_m[0]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // mode 0: base+i, 1: random keys, 2: all keys equal to base
   task automatic load_keys(input logic [KW-1:0] base, input int mode, input bit with_start);
      logic [63:0] r;
      for (int i = 0; i < int'(NR); i++) begin
         r = {$urandom, $urandom};
         case (mode)
            0:       round_keys_in[i] = base + KW'(i);
            1:       round_keys_in[i] = r[KW-1:0];
            default: round_keys_in[i] = base;
         endcase
      end
      key_load = 1'b1;
      start    = with_start;
      decrypt  = 1'b0;
      #1;
      chk("start_ready_during_load", 64'(start_ready), 64'(0));
      chk("key_load_ready_before_load", 64'(key_load_ready), 64'(1));
      @(negedge clk);
      key_load = 1'b0;
      start    = 1'b0;
      for (int i = 0; i < int'(NR); i++) bank_m[i] = round_keys_in[i];
      #1;
      chk("key_loaded_after_load", 64'(key_loaded), 64'(1));
      chk("rk_valid_after_load", 64'(rk_valid), 64'(0));
      chk("start_ready_after_load", 64'(start_ready), 64'(1));
`ifdef WEAK_KEY_DETECT_EN
      chk("weak_key", 64'(weak_key), 64'(model_all_equal()));
`endif
   endtask

   // Streams one block; every cycle the output is compared to the head of the expected order
   task automatic stream(input logic dec, input int stall_at, input int stall_len,
                         input int abort_at, input bit rnd_ready,
                         output int hs, output int dn,
                         output logic [KW-1:0] fk, output logic [KW-1:0] lk);
      logic [KW-1:0] q[$];
      int pos, stalled, cyc;
      bit active, aborted, rdy;
      hs = 0; dn = 0; fk = '0; lk = '0;
      pos = 0; stalled = 0; cyc = 0; active = 1'b1; aborted = 1'b0;
      for (int i = 0; i < int'(NR); i++) q.push_back(bank_m[dec ? int'(NR) - 1 - i : i]);
      start   = 1'b1;
      decrypt = dec;
      #1;
      chk("start_ready_at_start", 64'(start_ready), 64'(1));
      @(negedge clk);
      start   = 1'b0;
      decrypt = 1'b0;
      while (active && cyc < 200) begin
         chk("rk_valid", 64'(rk_valid), 64'(1));
         chk("rk_out", 64'(rk_out), 64'(q[pos]));
         chk("rk_round", 64'(rk_round), 64'(pos));
         chk("rk_last", 64'(rk_last), 64'(pos == int'(NR) - 1));
         chk("done_mid_stream", 64'(done), 64'(0));
         chk("key_load_ready_stream", 64'(key_load_ready), 64'(0));
         abort = (pos == abort_at);
         if (pos == stall_at && stalled < stall_len) begin
            rdy = 1'b0;
            stalled++;
         end else begin
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         rk_ready = rdy;
         if (abort) begin
            active  = 1'b0;
            aborted = 1'b1;
         end else if (rdy) begin
            hs++;
            if (pos == 0) fk = q[pos];
            if (pos == int'(NR) - 1) begin
               lk     = q[pos];
               active = 1'b0;
            end else begin
               pos++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      abort    = 1'b0;
      rk_ready = 1'b0;
      if (active) begin
         n_cmp++;
         n_bad++;
         $display("FAIL stream_timeout: stream still active after %0d cycles at pos %0d", cyc, pos);
      end
      chk("done_pulse", 64'(done), 64'(!aborted));
      if (done) dn++;
      chk("rk_valid_after_stream", 64'(rk_valid), 64'(0));
      chk("rk_out_after_stream", 64'(rk_out), 64'(0));
      chk("rk_round_after_stream", 64'(rk_round), 64'(0));
      chk("rk_last_after_stream", 64'(rk_last), 64'(0));
      chk("key_load_ready_after_stream", 64'(key_load_ready), 64'(1));
   endtask

   typedef struct {
      bit            do_load;
      logic [KW-1:0] base;
      logic          dec;
      int            stall_at;
      int            stall_len;
      int            abort_at;
      int            exp_hs;
      int            exp_done;
      logic [KW-1:0] exp_first;
      logic [KW-1:0] exp_last;
   } vec_t;

   initial begin
      vec_t          vecs [5];
      int            hs, dn;
      logic [KW-1:0] fk, lk;

      n_cmp = 0; n_bad = 0;
      rst = 1'b1; key_load = 1'b0; start = 1'b0; decrypt = 1'b0;
      rk_ready = 1'b0; abort = 1'b0;
      for (int i = 0; i < int'(NR); i++) round_keys_in[i] = '0;

      vecs[0] = '{1'b1, 48'hA5A5_0000_0000, 1'b0, -1, 0, -1, 16, 1, 48'hA5A5_0000_0000, 48'hA5A5_0000_000F};
      vecs[1] = '{1'b0, 48'h0,              1'b1, -1, 0, -1, 16, 1, 48'hA5A5_0000_000F, 48'hA5A5_0000_0000};
      vecs[2] = '{1'b0, 48'h0,              1'b0,  5, 3, -1, 16, 1, 48'hA5A5_0000_0000, 48'hA5A5_0000_000F};
      vecs[3] = '{1'b0, 48'h0,              1'b1,  0, 2, -1, 16, 1, 48'hA5A5_0000_000F, 48'hA5A5_0000_0000};
      vecs[4] = '{1'b0, 48'h0,              1'b0, -1, 0,  7,  7, 0, 48'hA5A5_0000_0000, 48'h0};

      repeat (2) @(negedge clk);
      chk("rst_key_loaded", 64'(key_loaded), 64'(0));
      chk("rst_rk_valid", 64'(rk_valid), 64'(0));
      chk("rst_rk_out", 64'(rk_out), 64'(0));
      chk("rst_rk_round", 64'(rk_round), 64'(0));
      chk("rst_rk_last", 64'(rk_last), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_key_load_ready", 64'(key_load_ready), 64'(1));
      chk("rst_start_ready", 64'(start_ready), 64'(0));
`ifdef WEAK_KEY_DETECT_EN
      chk("rst_weak_key", 64'(weak_key), 64'(0));
`endif
      rst = 1'b0;

      // start in IDLE must be ignored
      start = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_start_ignored", 64'(rk_valid), 64'(0));
         chk("idle_start_ready", 64'(start_ready), 64'(0));
      end
      start = 1'b0;

      foreach (vecs[v]) begin
         if (vecs[v].do_load) load_keys(vecs[v].base, 0, 1'b0);
         stream(vecs[v].dec, vecs[v].stall_at, vecs[v].stall_len, vecs[v].abort_at, 1'b0,
                hs, dn, fk, lk);
         chk($sformatf("vec%0d_handshakes", v), 64'(hs), 64'(vecs[v].exp_hs));
         chk($sformatf("vec%0d_done_count", v), 64'(dn), 64'(vecs[v].exp_done));
         chk($sformatf("vec%0d_first_key", v), 64'(fk), 64'(vecs[v].exp_first));
         chk($sformatf("vec%0d_last_key", v), 64'(lk), 64'(vecs[v].exp_last));
      end
      chk("after_abort_start_ready", 64'(start_ready), 64'(1));

      // simultaneous key_load + start: load wins, start not accepted
      load_keys(48'h1234_5678_9ABC, 0, 1'b1);
      stream(1'b0, -1, 0, -1, 1'b0, hs, dn, fk, lk);
      chk("load_start_first", 64'(fk), 64'(48'h1234_5678_9ABC));
      chk("load_start_last", 64'(lk), 64'(48'h1234_5678_9ACB));

      // synchronous reset mid-stream
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rk_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rk_ready = 1'b0;
      chk("midrst_rk_valid", 64'(rk_valid), 64'(0));
      chk("midrst_key_loaded", 64'(key_loaded), 64'(0));
      chk("midrst_rk_out", 64'(rk_out), 64'(0));
      chk("midrst_key_load_ready", 64'(key_load_ready), 64'(1));
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_start_ignored", 64'(rk_valid), 64'(0));
         chk("midrst_start_ready", 64'(start_ready), 64'(0));
      end
      start = 1'b0;

      // weak (all-equal) key then a normal key
      load_keys(48'h0, 2, 1'b0);
      load_keys(48'hA5A5_0000_0000, 0, 1'b0);
      stream(1'b1, -1, 0, -1, 1'b0, hs, dn, fk, lk);
      chk("post_rst_first", 64'(fk), 64'(48'hA5A5_0000_000F));

      // randomized traffic against the key-order model
      for (int it = 0; it < 30; it++) begin
         int ab;
         if ($urandom_range(0, 2) == 0) begin
            load_keys(48'(({$urandom, $urandom})), ($urandom_range(0, 4) == 0) ? 2 : 1, 1'b0);
         end
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
         stream(1'($urandom_range(0, 1)), -1, 0, ab, 1'b1, hs, dn, fk, lk);
         chk("rand_done_count", 64'(dn), 64'(ab < 0));
         if (ab < 0) chk("rand_handshakes", 64'(hs), 64'(NR));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/des_round_key_sequencer.md
Name: des_round_key_sequencer

Overview:
- Sits directly downstream of the combinational DES key schedule.
- Captures the full bank of round keys in one cycle, then streams them one per cycle to the iterative DES round engine over a valid/ready handshake.
- Order is forward (K1..K16) for encrypt and reverse (K16..K1) for decrypt.
- Decouples key-schedule timing from the round engine and allows one loaded key to be reused for many blocks.

Parameters:
- NUM_ROUNDS, 16: number of round keys held and streamed per block.
- KEY_W, 48: width of one round key.
- CNT_W, $clog2(NUM_ROUNDS): round counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- round_keys_in  in  KEY_W x [0:NUM_ROUNDS-1]  unpacked array from key schedule; index 0 = K1.
- key_load  in  1  capture round_keys_in into bank this cycle (accepted only when key_load_ready).
- key_load_ready  out  1  high in IDLE and LOADED; low in STREAM.
- key_loaded  out  1  bank holds a valid key.
- start  in  1  request one block's key stream.
- decrypt  in  1  sampled with start; 1 = reverse order.
- start_ready  out  1  = (state==LOADED) && !key_load.
- rk_valid  out  1  rk_out valid.
- rk_ready  in  1  round engine accepts rk_out.
- rk_out  out  KEY_W  current round key.
- rk_round  out  CNT_W  round index of rk_out in streaming order (0..NUM_ROUNDS-1).
- rk_last  out  1  rk_out is the final key of the block.
- abort  in  1  terminate stream.
- done  out  1  one-cycle pulse after the final key handshake.

Behaviour:
- Reset (sync; takes priority over every other input, including mid-stream): state=IDLE, bank all zero, counter=0, dir=0. Outputs: key_loaded=0, rk_valid=0, rk_out=0, rk_round=0, rk_last=0, done=0. key_load_ready=1 and start_ready=0 follow from the state.
- States:
  - IDLE: no key. key_load -> LOADED. start is ignored.
  - LOADED: key_load recaptures the bank and stays in LOADED. start&&start_ready latches dir=decrypt, counter=0 -> STREAM. Simultaneous key_load+start: load wins, start is not accepted (start_ready=0).
  - STREAM:
    - rk_valid=1 from the first cycle after start acceptance.
    - rk_out = bank[dir ? NUM_ROUNDS-1-counter : counter]; rk_round=counter; rk_last=(counter==NUM_ROUNDS-1).
    - Outputs are registered and held stable while rk_valid && !rk_ready.
    - On handshake with !rk_last: counter+1. On handshake with rk_last: -> LOADED, done=1 next cycle.
    - Counter never wraps; the last handshake exits the state.
    - abort (priority over handshake): -> LOADED next cycle, rk_valid=0, no done pulse.
    - key_load is ignored in STREAM (key_load_ready=0); the bank never changes mid-stream.
- Minimum latency: start accepted at cycle t -> first key valid at t+1 -> with rk_ready held high, last key at t+NUM_ROUNDS, done at t+NUM_ROUNDS+1.
- Back-to-back blocks: start may be accepted in the cycle done is high.
- Outside STREAM: rk_out=0, rk_round=0, rk_last=0.

Optional Feature:
- Macro: WEAK_KEY_DETECT_EN.
- Defined:
  - Adds output weak_key (1 bit), registered.
  - Set on the cycle after a key_load whose 16 captured round keys are all equal (DES weak keys).
  - Cleared by reset or a load of a non-weak key.
  - Streaming behaviour is unchanged.
- Undefined: no weak_key port and no comparator logic.

Test Plan:
- Reset then load with round_keys_in[i]=48'hA5A5_0000_0000+i, start with decrypt=0, rk_ready=1 -> rk_out A5A5_0000_0000..A5A5_0000_000F on consecutive cycles, rk_round 0..15, rk_last only on the 16th, done one cycle later.
- Same key, start with decrypt=1 -> rk_out ...000F down to ...0000, rk_round 0..15, rk_last on ...0000.
- Forward stream with rk_ready low for 3 cycles at round 5 -> rk_out=...0005 held stable for 3 cycles; 16 handshakes total; done still pulses once.
- key_load and start asserted together in LOADED with new key 48'h1234_5678_9ABC+i -> start_ready=0, new key captured; a later start streams 1234_5678_9ABC..+F.
- abort at round 7, then rst asserted mid-stream in a second run -> after abort: LOADED, rk_valid=0, no done pulse. After rst: IDLE, key_loaded=0, bank cleared, start ignored until the next key_load.
- With WEAK_KEY_DETECT_EN: load all 16 keys = 48'h0 -> weak_key=1; then load the incrementing key -> weak_key=0.
